if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Instruction-fetch controller for the pipelined CPU. Owns the program counter, drives the word address of the combinational instruction memory, and delivers `{pc, instruction}` pairs to the decode stage through a 2-entry buffer with a valid/ready handshake. Handles branch/jump redirects with flush, an external halt, and a sticky fault on out-of-range or misaligned fetch addresses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `IMEM_AW`, 8, instruction-memory word-index width; the valid byte range is 0 to 4·2^IMEM_AW − 1.
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, synchronous, active-high.
- `imem_addr`, out, 32, byte address to instruction memory; equals `fetch_pc`.
- `imem_instr`, in, 32, instruction word returned combinationally in the same cycle.
- `redirect_valid`, in, 1, branch/jump taken this cycle.
- `redirect_pc`, in, 32, target byte address.
- `halt`, in, 1, level signal; suspends new fetches.
- `out_valid`, out, 1, head buffer entry is valid.
- `out_ready`, in, 1, decode accepts the head entry.
- `out_pc`, out, 32, PC of the head entry.
- `out_instr`, out, 32, instruction of the head entry.
- `fault`, out, 1, sticky fetch fault.
- `fault_pc`, out, 32, PC that caused the fault.
- `retire_count`, out, 32, number of handshakes completed (`out_valid & out_ready`); wraps modulo 2^32.

## Operation
- **State machine** `{RUN, HOLD, FAULT}`. Reset enters RUN.
  - RUN → HOLD when `halt`.
  - HOLD → RUN when `!halt`.
  - Any state → FAULT on a bad fetch.
  - FAULT → RUN (or HOLD, if `halt`) only on `redirect_valid` or `reset`.
- **Bad fetch:** `fetch_pc[1:0] != 0`, or `fetch_pc[31:IMEM_AW+2] != 0`. The entry is not pushed. `fault` is set to 1 and `fault_pc` to `fetch_pc`.
- **Pop:** `out_valid & out_ready` dequeues the head and increments `retire_count`.
- **Push:** occurs in RUN when the fetch is good, `!redirect_valid`, and (`count < 2` or pop this cycle). It writes `{fetch_pc, imem_instr}` to the tail and sets `fetch_pc <= fetch_pc + 4`, wrapping modulo 2^32.
- **Redirect** has the highest priority:
  - Flushes the buffer (`count <= 0`) and discards any same-cycle push.
  - A pop in the same cycle still completes and still counts.
  - Sets `fetch_pc <= redirect_pc`, clears `fault`, and leaves FAULT.
  - A misaligned `redirect_pc` is accepted; the fault is raised on the following fetch cycle.
- HOLD and FAULT perform no push. The buffer keeps draining to decode.
- The buffer is strictly FIFO. `out_*` are driven from the registered head with no combinational path from `imem_instr` to `out_instr`.

## Timing
- **Reset values:** `fetch_pc = RESET_PC`, `count = 0`, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`, `fault = 0`, `fault_pc = 0`, `retire_count = 0`, state RUN.
- **Fetch latency:** fetch in cycle N, visible on `out_*` in cycle N+1. First `out_valid` is the 2nd cycle after reset deasserts.
- **Redirect latency:** redirect in cycle N, fetch of the target in N+1, `out_valid` with the target in N+2. `out_valid = 0` in N+1.
- **Throughput:** sustained one instruction per cycle while `out_ready = 1`.
- **Full buffer with `out_ready = 0`:** `fetch_pc` holds and `imem_addr` is stable.
- **Combinational path:** `out_ready` to push decision is the only combinational path through the block.
- **Reset mid-operation:** overrides everything, including a simultaneous redirect.

## Structure
- **Shared package `if_pkg`:**
  - state enum `fetch_state_t`
  - `FETCH_BUF_DEPTH = 2`
  - `NOP_WORD = 32'h0000_0000`
  - struct `fetch_entry_t {pc[31:0], instr[31:0]}`, shared with decode.
- **Sub-module `fetch_buf`:** 2-entry synchronous FIFO of `fetch_entry_t`, with a `flush` input, simultaneous push/pop at full, and `count` output. The controller holds the PC, the FSM, fault tracking and `retire_count`.

## Test plan
All scenarios use the program image: word0 `32'h2004_0007`, word1 `32'h2005_0008`, word2 `32'h0085_3020`.

1. **Reset then run:** release `reset`, hold `out_ready = 1`.
   - `out_valid` rises in the 2nd cycle after release.
   - Outputs are (0, 2004_0007), (4, 2005_0008), (8, 0085_3020), one per cycle.
   - `retire_count = 3` after three cycles.
2. **Backpressure:** `out_ready = 0` for 5 cycles after the first valid.
   - `count` saturates at 2 and `imem_addr` holds at 8.
   - On `out_ready = 1`, outputs PC 0, 4, 8 in order with no loss or duplicate.
3. **Redirect:** `redirect_pc = 4` asserted with `out_ready = 1` while the head is PC 0.
   - The PC 0 handshake counts and the buffer flushes.
   - One bubble cycle follows, then PC 4, then PC 8.
4. **Halt:** `halt = 1` for 4 cycles.
   - No new PCs enter and the buffer drains.
   - After `halt = 0`, fetch resumes at the next sequential PC.
5. **Fault:**
   - Redirect to `32'h0000_0400` gives `fault = 1` and `fault_pc = 32'h400` two cycles later, with no `out_valid`.
   - Redirect to 0 clears `fault`; PC 0 is delivered two cycles later.
   - Redirect to `32'h2` faults with `fault_pc = 2`.
6. **Reset with buffer full:** assert `reset` together with `redirect_valid`.
   - Next cycle all outputs are at reset values and `imem_addr = RESET_PC`.

Source files
------------

// File: rtl/if_pkg.sv
// Shared fetch-stage types: controller states, buffer entry layout and
// the fetch address legality check used by the controller.
package if_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int FETCH_BUF_DEPTH = 2;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A fetch is illegal if misaligned or outside the 2^aw-word instruction memory.
    function automatic logic fetch_addr_bad(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] hi_mask;
        hi_mask = ~((32'd1 << (aw + 32'd2)) - 32'd1);
        return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries between the fetch controller and
// decode. Head is read straight from registers; flush empties it in one cycle.
module fetch_buf
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         srst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full
);

    localparam int PTR_W = $clog2(FETCH_BUF_DEPTH);
    localparam logic [1:0] DEPTH_CNT = 2'(FETCH_BUF_DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             push_ok;
    logic             pop_ok;
    fetch_entry_t     slot [FETCH_BUF_DEPTH];

    assign full    = (count_reg == DEPTH_CNT);
    assign pop_ok  = pop && (count_reg != 2'd0);
    // A pop frees the head slot, so a push into a full buffer is still legal.
    assign push_ok = push && !flush && (!full || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_BUF_DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    slot_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= push_data;
                end
            end
            assign slot[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign head  = slot[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational
// instruction memory and hands {pc, instr} to decode through fetch_buf.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] retire_count
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  fetch_pc_next;
    logic         fault_reg;
    logic         fault_next;
    logic [31:0]  fault_pc_reg;
    logic [31:0]  fault_pc_next;
    logic [31:0]  retire_count_reg;

    logic         push;
    logic         pop;
    logic         addr_bad;
    logic [1:0]   buf_count;
    logic         buf_full;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign out_valid  = (buf_count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign addr_bad   = fetch_addr_bad(fetch_pc_reg, IMEM_AW);
    assign push_entry = '{pc: fetch_pc_reg, instr: imem_instr};

    // Redirect outranks everything but reset; halt blocks pushes immediately,
    // while the HOLD state adds one cycle of restart latency after release.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        push          = 1'b0;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            fault_next    = 1'b0;
            state_next    = halt ? HOLD : RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (addr_bad) begin
                        state_next    = FAULT;
                        fault_next    = 1'b1;
                        fault_pc_next = fetch_pc_reg;
                    end else if (halt) begin
                        state_next = HOLD;
                    end else if (!buf_full || pop) begin
                        push          = 1'b1;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end
                HOLD: begin
                    if (addr_bad) begin
                        state_next    = FAULT;
                        fault_next    = 1'b1;
                        fault_pc_next = fetch_pc_reg;
                    end else if (!halt) begin
                        state_next = RUN;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= RUN;
            fetch_pc_reg     <= RESET_PC;
            fault_reg        <= 1'b0;
            fault_pc_reg     <= 32'd0;
            retire_count_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
            if (pop) begin
                retire_count_reg <= retire_count_reg + 32'd1;
            end
        end
    end

    fetch_buf u_fetch_buf (
        .clk       (clk),
        .srst      (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (buf_count),
        .full      (buf_full)
    );

    assign imem_addr    = fetch_pc_reg;
    assign out_pc       = head_entry.pc;
    assign out_instr    = head_entry.instr;
    assign fault        = fault_reg;
    assign fault_pc     = fault_pc_reg;
    assign retire_count = retire_count_reg;

endmodule
